di_byte_fifo: RTL
=================

Name: di_byte_fifo

Overview:
Byte-side terminal for the word-to-byte DI stage. It consumes that stage's byte-wide write/read handshake and decouples it from an external byte stream through two FIFOs. The TX FIFO takes DI byte writes and drains to a valid/ready output stream. The RX FIFO fills from a valid/ready input stream and serves DI byte reads. The block sits directly downstream of the word-to-byte converter, between it and a byte peripheral such as a UART or FX2 FIFO shim.

Parameters:
DEPTH_LOG2, 4, log2 of each FIFO depth (DEPTH = 2**DEPTH_LOG2; minimum 2).

Ports:
ifclk  input  1  clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
enable  input  1  0 = flush both FIFOs and clear flags, every cycle held low
flush  input  1  1-cycle pulse: same effect as enable low for one cycle
di1_write  input  1  push di1_reg_datai into TX FIFO
di1_reg_datai  input  8  write byte
di1_write_rdy  output  1  TX FIFO can accept at least 2 more bytes
di1_read_req  input  1  converter requests a byte
di1_read  input  1  pop RX head; converter samples di1_reg_datao this cycle
di1_reg_datao  output  8  RX FIFO head byte (combinational from array)
di1_read_rdy  output  1  request pending and RX not empty
tx_data  output  8  TX FIFO head byte
tx_valid  output  1  TX not empty
tx_ready  input  1  consumer takes tx_data when tx_valid && tx_ready
rx_data  input  8  incoming byte
rx_valid  input  1  incoming byte present
rx_ready  output  1  RX not full
tx_count  output  DEPTH_LOG2+1  TX occupancy, 0..DEPTH
rx_count  output  DEPTH_LOG2+1  RX occupancy, 0..DEPTH
overflow  output  1  sticky: di1_write while TX full
underflow  output  1  sticky: di1_read while RX empty

Behaviour:
- Reset (sync, reset=1 at edge):
  - All pointers and counts go to 0. pending, overflow and underflow go to 0.
  - Resulting outputs: tx_valid=0, di1_read_rdy=0, rx_ready=1, di1_write_rdy=1, counts=0.
  - di1_reg_datao and tx_data are don't-care while their FIFO is empty.
  - Array contents are not reset.
- Priority: reset > (!enable or flush) > normal operation. The flush condition has the same effect as reset, but only while enable is low or on the flush cycle.
- Each FIFO:
  - Write and read pointers are DEPTH_LOG2+1 bits wide and wrap naturally.
  - full = MSBs differ and LSBs equal. empty = pointers equal.
  - count = wptr - rptr, registered via the pointers.
  - A push writes the array at wptr[DEPTH_LOG2-1:0]. A pop advances rptr.
  - Head data is read combinationally from array[rptr].
  - Push and pop in the same cycle: both occur, count unchanged.
  - A push is accepted only if not full at cycle start, even when a pop occurs in the same cycle.
  - A pop is accepted only if not empty at cycle start.
- Latency: a byte pushed at edge N is visible at head and in count after edge N; earliest pop is at edge N+1.
- TX path:
  - push = di1_write && !tx_full. di1_write while full: byte dropped, overflow<=1.
  - pop = tx_valid && tx_ready.
  - di1_write_rdy = (DEPTH - tx_count) >= 2. This is registered-count based; the one-byte margin absorbs a write already in flight when rdy falls.
- RX path:
  - push = rx_valid && rx_ready, with rx_ready = !rx_full.
  - pending: set on di1_read_req, cleared on accepted or rejected di1_read. If both are high in the same cycle, clear wins.
  - di1_read_rdy = pending && !rx_empty.
  - pop = di1_read && !rx_empty; data is taken from di1_reg_datao in the same cycle.
  - di1_read while empty: no pointer change, underflow<=1.
- Sticky flags clear only on reset, !enable or flush.
- Reset or flush mid-transfer discards all queued bytes. The handshake on that cycle is ignored: no push, no pop, no flag set.
- No combinational path from di1_write, di1_read, rx_valid or tx_ready to any ready/valid output. All status outputs derive from registered state.

Test Plan:
- Reset, then enable=1. Write 0x11,0x22,0x33 via di1_write with tx_ready=0 -> tx_count=3, tx_valid=1, tx_data=0x11. Set tx_ready=1 -> 0x11,0x22,0x33 appear on consecutive cycles, then tx_valid=0.
- DEPTH_LOG2=2, tx_ready=0. Write 5 bytes -> di1_write_rdy falls when tx_count=3. 4th byte accepted (tx_count=4). 5th dropped, overflow=1. Drain -> 4 bytes in order.
- Push 0xA5,0x5A on rx_valid. Pulse di1_read_req, then di1_read when di1_read_rdy -> datao=0xA5 at the pop edge, rx_count=1, di1_read_rdy=0 until the next request.
- Fill RX to DEPTH -> rx_ready=0, rx_valid held high, no push. Same-cycle di1_read -> count stays DEPTH-1 after the pop. Next cycle the push is accepted and count returns to DEPTH.
- Wrap-around: stream 3×DEPTH+1 bytes through each FIFO with random valid/ready -> output sequence equals input. Counts never exceed DEPTH. No flags set.
- With both FIFOs partly full, assert flush for 1 cycle -> counts=0, tx_valid=0, flags cleared. Repeat with enable=0 and with reset=1 -> same result.

Source files
------------

// File: rtl/di_byte_fifo_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | di_byte_fifo_if : DI byte handshake and byte-stream bundle         |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface di_byte_fifo_if #(
   parameter int DEPTH_LOG2 = 4
);
   logic                  di1_write;
   logic [7:0]            di1_reg_datai;
   logic                  di1_write_rdy;
   logic                  di1_read_req;
   logic                  di1_read;
   logic [7:0]            di1_reg_datao;
   logic                  di1_read_rdy;
   logic [7:0]            tx_data;
   logic                  tx_valid;
   logic                  tx_ready;
   logic [7:0]            rx_data;
   logic                  rx_valid;
   logic                  rx_ready;
   logic [DEPTH_LOG2:0]   tx_count;
   logic [DEPTH_LOG2:0]   rx_count;
   logic                  overflow;
   logic                  underflow;

   modport slave (
      input  di1_write, di1_reg_datai, di1_read_req, di1_read, tx_ready, rx_data, rx_valid,
      output di1_write_rdy, di1_reg_datao, di1_read_rdy, tx_data, tx_valid, rx_ready,
             tx_count, rx_count, overflow, underflow
   );

   modport master (
      output di1_write, di1_reg_datai, di1_read_req, di1_read, tx_ready, rx_data, rx_valid,
      input  di1_write_rdy, di1_reg_datao, di1_read_rdy, tx_data, tx_valid, rx_ready,
             tx_count, rx_count, overflow, underflow
   );
endinterface
`default_nettype wire

// File: rtl/di_byte_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | di_byte_fifo : TX/RX byte FIFOs between the DI converter and a     |
// |                valid/ready byte stream. rev 1.0                    |
// +--------------------------------------------------------------------+
module di_byte_fifo #(
   parameter int DEPTH_LOG2 = 4
) (
   input  wire logic          ifclk,
   input  wire logic          reset,
   input  wire logic          enable,
   input  wire logic          flush,
   di_byte_fifo_if.slave      bus
);
   localparam int                  c_DEPTH     = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] c_PTR_ONE   = (DEPTH_LOG2+1)'(1);
   localparam logic [DEPTH_LOG2:0] c_RDY_LIMIT = (DEPTH_LOG2+1)'(c_DEPTH - 2);

   logic w_clear;
   assign w_clear = reset || !enable || flush;

   // ---------------- TX FIFO: DI writes -> tx stream ----------------
   logic [7:0]          r_tx_mem [c_DEPTH];
   logic [DEPTH_LOG2:0] r_tx_wptr;
   logic [DEPTH_LOG2:0] r_tx_rptr;
   logic [DEPTH_LOG2:0] w_tx_count;
   logic                w_tx_full;
   logic                w_tx_empty;
   logic                w_tx_push;
   logic                w_tx_pop;
   logic                r_overflow;

   assign w_tx_count = r_tx_wptr - r_tx_rptr;
   assign w_tx_empty = (r_tx_wptr == r_tx_rptr);
   assign w_tx_full  = (r_tx_wptr[DEPTH_LOG2] != r_tx_rptr[DEPTH_LOG2]) &&
                       (r_tx_wptr[DEPTH_LOG2-1:0] == r_tx_rptr[DEPTH_LOG2-1:0]);
   assign w_tx_push  = bus.di1_write && !w_tx_full;
   assign w_tx_pop   = !w_tx_empty && bus.tx_ready;

   always_ff @(posedge ifclk) begin
      if (w_clear) begin
         r_tx_wptr  <= '0;
         r_tx_rptr  <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_tx_push)
            r_tx_wptr <= r_tx_wptr + c_PTR_ONE;
         if (w_tx_pop)
            r_tx_rptr <= r_tx_rptr + c_PTR_ONE;
         if (bus.di1_write && w_tx_full)
            r_overflow <= 1'b1;
      end
   end

   always_ff @(posedge ifclk) begin
      if (!w_clear && w_tx_push)
         r_tx_mem[r_tx_wptr[DEPTH_LOG2-1:0]] <= bus.di1_reg_datai;
   end

   // Ready keeps one slot spare so a write already in flight when it drops still lands.
   assign bus.di1_write_rdy = (w_tx_count <= c_RDY_LIMIT);
   assign bus.tx_valid      = !w_tx_empty;
   assign bus.tx_data       = r_tx_mem[r_tx_rptr[DEPTH_LOG2-1:0]];
   assign bus.tx_count      = w_tx_count;
   assign bus.overflow      = r_overflow;

   // ---------------- RX FIFO: rx stream -> DI reads ----------------
   logic [7:0]          r_rx_mem [c_DEPTH];
   logic [DEPTH_LOG2:0] r_rx_wptr;
   logic [DEPTH_LOG2:0] r_rx_rptr;
   logic [DEPTH_LOG2:0] w_rx_count;
   logic                w_rx_full;
   logic                w_rx_empty;
   logic                w_rx_push;
   logic                w_rx_pop;
   logic                r_pending;
   logic                r_underflow;

   assign w_rx_count = r_rx_wptr - r_rx_rptr;
   assign w_rx_empty = (r_rx_wptr == r_rx_rptr);
   assign w_rx_full  = (r_rx_wptr[DEPTH_LOG2] != r_rx_rptr[DEPTH_LOG2]) &&
                       (r_rx_wptr[DEPTH_LOG2-1:0] == r_rx_rptr[DEPTH_LOG2-1:0]);
   assign w_rx_push  = bus.rx_valid && !w_rx_full;
   assign w_rx_pop   = bus.di1_read && !w_rx_empty;

   always_ff @(posedge ifclk) begin
      if (w_clear) begin
         r_rx_wptr   <= '0;
         r_rx_rptr   <= '0;
         r_pending   <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         if (w_rx_push)
            r_rx_wptr <= r_rx_wptr + c_PTR_ONE;
         if (w_rx_pop)
            r_rx_rptr <= r_rx_rptr + c_PTR_ONE;
         if (bus.di1_read && w_rx_empty)
            r_underflow <= 1'b1;
         // Any read, accepted or not, retires the request; it beats a same-cycle new request.
         if (bus.di1_read)
            r_pending <= 1'b0;
         else if (bus.di1_read_req)
            r_pending <= 1'b1;
      end
   end

   always_ff @(posedge ifclk) begin
      if (!w_clear && w_rx_push)
         r_rx_mem[r_rx_wptr[DEPTH_LOG2-1:0]] <= bus.rx_data;
   end

   assign bus.rx_ready      = !w_rx_full;
   assign bus.di1_read_rdy  = r_pending && !w_rx_empty;
   assign bus.di1_reg_datao = r_rx_mem[r_rx_rptr[DEPTH_LOG2-1:0]];
   assign bus.rx_count      = w_rx_count;
   assign bus.underflow     = r_underflow;

endmodule
`default_nettype wire
